// File: rtl/mod_instruction_fetch.sv
// mod_instruction_fetch: upstream fetch stage for the MIPS core.
// The stage fetches the 32-bit word at the core's current PC from a
// variable-latency instruction memory that uses a request/response handshake.
// It keeps the word in a one-entry tagged buffer and holds the core until the
// word for the current PC is valid.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   pc                  current PC from the core
//   instruction         buffered instruction word (registered)
//   hold                combinational; 1 = core must not advance its PC
//   imem_req/imem_addr  fetch request and address (registered)
//   imem_ready          memory accepts the request this cycle
//   imem_rvalid/rdata   read response; only looked at in WAIT
//   fetch_error         sticky error: misaligned PC or memory timeout
module mod_instruction_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] RESET_INSTR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fetch_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               buf_valid_q, buf_valid_d;
  logic [31:0]        buf_tag_q, buf_tag_d;
  logic [31:0]        instr_q, instr_d;
  logic               req_q, req_d;
  logic [31:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic hit_c;
  logic misaligned_c;

  // The buffered word only counts as a hit while idle.
  assign hit_c        = (state_q == ST_IDLE) && buf_valid_q && (buf_tag_q == pc);
  assign misaligned_c = (pc[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (misaligned_c) begin
          state_d = ST_ERROR;
        end else if (!hit_c) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (imem_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response in the last allowed cycle still wins over the timeout.
        if (imem_rvalid) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output / datapath next values
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    req_d       = (state_d == ST_REQ);
    err_d       = err_q | (state_d == ST_ERROR);
    case (state_q)
      ST_IDLE: begin
        // imem_addr only moves when a new request is launched.
        if (state_d == ST_REQ) begin
          addr_d = pc;
        end
      end
      ST_REQ: begin
        if (imem_ready) begin
          cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          instr_d     = imem_rdata;
          buf_tag_d   = addr_q;
          buf_valid_d = 1'b1;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      instr_q     <= RESET_INSTR;
      req_q       <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      instr_q     <= instr_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign hold        = reset | err_q | ~hit_c;
  assign instruction = instr_q;
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign fetch_error = err_q;

endmodule
